oled_vga_scaler: RTL and testbench



---
 rtl/oled_vga_scaler_if.sv | 24 ++
 rtl/oled_vga_scaler.sv | 282 ++++++++++++++++++++++++++++
 tb/tb_oled_vga_scaler.sv | 275 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/oled_vga_scaler_if.sv
// Pin bundle between the SSD1306 SPI header, the OLED-to-VGA scaler and the VGA PMOD.
// The scaler takes the slave side; whatever drives the SPI pins takes the master side.
interface oled_vga_scaler_if;
  logic       spi_sck;
  logic       spi_mosi;
  logic       spi_cs_n;
  logic       spi_dc;
  logic [3:0] vga_r;
  logic [3:0] vga_g;
  logic [3:0] vga_b;
  logic       vga_hsync;
  logic       vga_vsync;
  logic       frame_done;

  modport master (
    output spi_sck, spi_mosi, spi_cs_n, spi_dc,
    input  vga_r, vga_g, vga_b, vga_hsync, vga_vsync, frame_done
  );

  modport slave (
    input  spi_sck, spi_mosi, spi_cs_n, spi_dc,
    output vga_r, vga_g, vga_b, vga_hsync, vga_vsync, frame_done
  );
endinterface

// File: rtl/oled_vga_scaler.sv
// Oversampled SSD1306 SPI capture into a page framebuffer, rendered centred and upscaled on a VGA raster.
// Optional: define OLED_VGA_CMD_DECODE_EN to honour the inverse (A6/A7) and display on/off (AE/AF) commands.
module oled_vga_scaler #(
  parameter int         H_PULSE      = 96,
  parameter int         H_BP         = 48,
  parameter int         H_PIXELS     = 640,
  parameter int         H_FP         = 16,
  parameter int         V_PULSE      = 2,
  parameter int         V_BP         = 31,
  parameter int         V_PIXELS     = 480,
  parameter int         V_FP         = 11,
  parameter int         OLED_W       = 128,
  parameter int         OLED_H       = 64,
  parameter int         SCALE        = 4,
  parameter int         BORDER       = 10,
  parameter logic [3:0] FG_COLOR     = 4'hF,
  parameter logic [3:0] BG_COLOR     = 4'h0,
  parameter logic [3:0] BORDER_COLOR = 4'hF
) (
  input  logic              clk,
  input  logic              greset,
  oled_vga_scaler_if.slave  bus
);

  localparam int H_FRAME = H_PULSE + H_BP + H_PIXELS + H_FP;
  localparam int V_FRAME = V_PULSE + V_BP + V_PIXELS + V_FP;
  localparam int HW      = $clog2(H_FRAME);
  localparam int VW      = $clog2(V_FRAME);
  localparam int DEPTH   = OLED_W * OLED_H / 8;
  localparam int AW      = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int XW      = (OLED_W > 1) ? $clog2(OLED_W) : 1;
  localparam int YW      = $clog2(OLED_H);
  localparam int SW      = (SCALE > 1) ? $clog2(SCALE) : 1;
  localparam int PANEL_W = OLED_W * SCALE;
  localparam int PANEL_H = OLED_H * SCALE;
  localparam int H_OFF   = H_PULSE + H_BP + (H_PIXELS - PANEL_W) / 2;
  localparam int V_OFF   = V_PULSE + V_BP + (V_PIXELS - PANEL_H) / 2;

  localparam logic [HW-1:0] H_LAST     = HW'(H_FRAME - 1);
  localparam logic [VW-1:0] V_LAST     = VW'(V_FRAME - 1);
  localparam logic [HW-1:0] H_SYNC_END = HW'(H_PULSE);
  localparam logic [VW-1:0] V_SYNC_END = VW'(V_PULSE);
  localparam logic [HW-1:0] H_PRE      = HW'(H_OFF - 1);
  localparam logic [VW-1:0] V_PRE      = VW'(V_OFF - 1);
  localparam logic [HW-1:0] H_PAN_LO   = HW'(H_OFF);
  localparam logic [HW-1:0] H_PAN_HI   = HW'(H_OFF + PANEL_W);
  localparam logic [VW-1:0] V_PAN_LO   = VW'(V_OFF);
  localparam logic [VW-1:0] V_PAN_HI   = VW'(V_OFF + PANEL_H);
  localparam logic [HW-1:0] H_BRD_LO   = HW'(H_OFF - BORDER);
  localparam logic [HW-1:0] H_BRD_HI   = HW'(H_OFF + PANEL_W + BORDER);
  localparam logic [VW-1:0] V_BRD_LO   = VW'(V_OFF - BORDER);
  localparam logic [VW-1:0] V_BRD_HI   = VW'(V_OFF + PANEL_H + BORDER);
  localparam logic [SW-1:0] SUB_LAST   = SW'(SCALE - 1);
  localparam logic [AW-1:0] ADDR_LAST  = AW'(DEPTH - 1);

  // ---------------- SPI input synchronisers ----------------
  logic [2:0] sck_q;
  logic [2:0] cs_q;
  logic [1:0] mosi_q;
  logic [1:0] dc_q;

  // NOTE: every clocked register uses non-blocking assignment so all flops sample pre-edge values.
  always_ff @(posedge clk) begin
    if (greset) begin
      sck_q  <= 3'b000;
      cs_q   <= 3'b111;
      mosi_q <= 2'b00;
      dc_q   <= 2'b00;
    end else begin
      sck_q  <= {sck_q[1:0], bus.spi_sck};
      cs_q   <= {cs_q[1:0], bus.spi_cs_n};
      mosi_q <= {mosi_q[0], bus.spi_mosi};
      dc_q   <= {dc_q[0], bus.spi_dc};
    end
  end

  logic sck_rise, cs_rise, cs_active;
  assign sck_rise  = sck_q[1] & ~sck_q[2];
  assign cs_rise   = cs_q[1] & ~cs_q[2];
  assign cs_active = ~cs_q[1];

  // ---------------- Byte capture ----------------
  logic [2:0]    bit_cnt;
  logic [7:0]    shift_q;
  logic [AW-1:0] waddr;
  logic          frame_done_q;
  logic [7:0]    byte_next;
  logic          byte_done;
  logic          mem_we;

  assign byte_next = {shift_q[6:0], mosi_q[1]};
  assign byte_done = sck_rise & cs_active & (bit_cnt == 3'd7);
  assign mem_we    = byte_done & dc_q[1];

  always_ff @(posedge clk) begin
    if (greset) begin
      bit_cnt      <= 3'd0;
      shift_q      <= 8'h00;
      waddr        <= '0;
      frame_done_q <= 1'b0;
    end else begin
      frame_done_q <= 1'b0;
      if (cs_rise) begin
        bit_cnt <= 3'd0;
        waddr   <= '0;
      end else if (sck_rise && cs_active) begin
        shift_q <= byte_next;
        bit_cnt <= bit_cnt + 3'd1;
        if (mem_we) begin
          if (waddr == ADDR_LAST) begin
            waddr        <= '0;
            frame_done_q <= 1'b1;
          end else begin
            waddr <= waddr + AW'(1);
          end
        end
      end
    end
  end

  // ---------------- Command decode ----------------
  logic inverse_q;
  logic disp_on_q;
`ifdef OLED_VGA_CMD_DECODE_EN
  logic [2:0] arg_cnt;

  // Argument counts of the multi-byte SSD1306 commands, so their operands are skipped.
  function automatic logic [2:0] cmd_args(input logic [7:0] cmd);
    case (cmd)
      8'h20, 8'h81, 8'h8D, 8'hA8, 8'hD3,
      8'hD5, 8'hD9, 8'hDA, 8'hDB:         return 3'd1;
      8'h21, 8'h22, 8'hA3:                return 3'd2;
      8'h29, 8'h2A:                       return 3'd5;
      8'h26, 8'h27:                       return 3'd6;
      default:                            return 3'd0;
    endcase
  endfunction

  always_ff @(posedge clk) begin
    if (greset) begin
      inverse_q <= 1'b0;
      disp_on_q <= 1'b1;
      arg_cnt   <= 3'd0;
    end else if (cs_rise) begin
      arg_cnt <= 3'd0;
    end else if (byte_done && !dc_q[1]) begin
      if (arg_cnt != 3'd0) begin
        arg_cnt <= arg_cnt - 3'd1;
      end else begin
        arg_cnt <= cmd_args(byte_next);
        case (byte_next)
          8'hA6:   inverse_q <= 1'b0;
          8'hA7:   inverse_q <= 1'b1;
          8'hAE:   disp_on_q <= 1'b0;
          8'hAF:   disp_on_q <= 1'b1;
          default: ;
        endcase
      end
    end
  end
`else
  assign inverse_q = 1'b0;
  assign disp_on_q = 1'b1;
`endif

  // ---------------- Raster and sub-pixel counters ----------------
  logic [HW-1:0] h_pos;
  logic [VW-1:0] v_pos;
  logic [XW-1:0] col;
  logic [SW-1:0] col_sub;
  logic [YW-1:0] row;
  logic [SW-1:0] row_sub;

  always_ff @(posedge clk) begin
    if (greset) begin
      h_pos   <= '0;
      v_pos   <= '0;
      col     <= '0;
      col_sub <= '0;
      row     <= '0;
      row_sub <= '0;
    end else begin
      if (h_pos == H_LAST) begin
        h_pos <= '0;
        v_pos <= (v_pos == V_LAST) ? '0 : v_pos + VW'(1);
        if (v_pos == V_PRE) begin
          row     <= '0;
          row_sub <= '0;
        end else if (row_sub == SUB_LAST) begin
          row_sub <= '0;
          row     <= row + YW'(1);
        end else begin
          row_sub <= row_sub + SW'(1);
        end
      end else begin
        h_pos <= h_pos + HW'(1);
      end

      // Column counters are primed one clock before the panel so X=0 on its first pixel.
      if (h_pos == H_PRE) begin
        col     <= '0;
        col_sub <= '0;
      end else if (col_sub == SUB_LAST) begin
        col_sub <= '0;
        col     <= col + XW'(1);
      end else begin
        col_sub <= col_sub + SW'(1);
      end
    end
  end

  logic in_panel, in_border;
  assign in_panel  = (h_pos >= H_PAN_LO) && (h_pos < H_PAN_HI) &&
                     (v_pos >= V_PAN_LO) && (v_pos < V_PAN_HI);
  assign in_border = (h_pos >= H_BRD_LO) && (h_pos < H_BRD_HI) &&
                     (v_pos >= V_BRD_LO) && (v_pos < V_BRD_HI);

  // ---------------- Three-stage render pipeline ----------------
  logic [AW-1:0] raddr;
  logic [2:0]    bit_s1, bit_s2;
  logic          panel_s1, panel_s2, border_s1, border_s2;
  logic          hs_s1, hs_s2, vs_s1, vs_s2;
  logic [3:0]    color_q;
  logic          hsync_q, vsync_q;
  logic [7:0]    rd_data;
  logic [7:0]    mem [DEPTH];

  // NOTE: the framebuffer has no reset so it maps onto block RAM; a same-address write returns the old byte.
  always_ff @(posedge clk) begin
    if (mem_we) mem[waddr] <= byte_next;
    rd_data <= mem[raddr];
  end

  logic pix_on;
  assign pix_on = rd_data[bit_s2] ^ inverse_q;

  always_ff @(posedge clk) begin
    if (greset) begin
      raddr     <= '0;
      bit_s1    <= 3'd0;
      bit_s2    <= 3'd0;
      panel_s1  <= 1'b0;
      panel_s2  <= 1'b0;
      border_s1 <= 1'b0;
      border_s2 <= 1'b0;
      hs_s1     <= 1'b1;
      hs_s2     <= 1'b1;
      vs_s1     <= 1'b1;
      vs_s2     <= 1'b1;
      color_q   <= BG_COLOR;
      hsync_q   <= 1'b1;
      vsync_q   <= 1'b1;
    end else begin
      raddr     <= AW'(row >> 3) * AW'(OLED_W) + AW'(col);
      bit_s1    <= row[2:0];
      panel_s1  <= in_panel;
      border_s1 <= in_border;
      hs_s1     <= (h_pos >= H_SYNC_END);
      vs_s1     <= (v_pos >= V_SYNC_END);

      bit_s2    <= bit_s1;
      panel_s2  <= panel_s1;
      border_s2 <= border_s1;
      hs_s2     <= hs_s1;
      vs_s2     <= vs_s1;

      if (panel_s2)       color_q <= (disp_on_q && pix_on) ? FG_COLOR : BG_COLOR;
      else if (border_s2) color_q <= BORDER_COLOR;
      else                color_q <= BG_COLOR;
      hsync_q <= hs_s2;
      vsync_q <= vs_s2;
    end
  end

  assign bus.vga_r      = color_q;
  assign bus.vga_g      = color_q;
  assign bus.vga_b      = color_q;
  assign bus.vga_hsync  = hsync_q;
  assign bus.vga_vsync  = vsync_q;
  assign bus.frame_done = frame_done_q;

endmodule

// File: tb/tb_oled_vga_scaler.sv
// Directed bench for oled_vga_scaler on a shrunken raster (8x16 panel, x3 scale, 44x62 frame) so
// every scenario fits in a few frames; expected pixels are hand-computed from that geometry.
module tb_oled_vga_scaler;

  localparam int H_PULSE = 4, H_BP = 4, H_PIXELS = 32, H_FP = 4;
  localparam int V_PULSE = 2, V_BP = 2, V_PIXELS = 56, V_FP = 2;
  localparam int H_FRAME = 44;
  localparam int V_FRAME = 62;
  localparam int FRAME   = H_FRAME * V_FRAME;  // 2728 clocks

  // Panel h 12..35, v 8..55; border window h 10..37, v 6..57.
  localparam int PAN_H0 = 12, PAN_H1 = 35, PAN_V0 = 8, PAN_V1 = 55;
  localparam int BRD_H0 = 10, BRD_H1 = 37, BRD_V0 = 6, BRD_V1 = 57;

  logic clk = 1'b0;
  logic greset = 1'b1;
  always #5 clk = ~clk;

  oled_vga_scaler_if bus ();

  oled_vga_scaler #(
    .H_PULSE (H_PULSE), .H_BP (H_BP), .H_PIXELS (H_PIXELS), .H_FP (H_FP),
    .V_PULSE (V_PULSE), .V_BP (V_BP), .V_PIXELS (V_PIXELS), .V_FP (V_FP),
    .OLED_W (8), .OLED_H (16), .SCALE (3), .BORDER (2),
    .FG_COLOR (4'hF), .BG_COLOR (4'h0), .BORDER_COLOR (4'hF)
  ) dut (
    .clk    (clk),
    .greset (greset),
    .bus    (bus)
  );

  // Raster position model; d3 is the position whose colour is on the outputs (3-clock pipeline).
  int th = 0, tv = 0, d1h = 0, d1v = 0, d2h = 0, d2v = 0, d3h = 0, d3v = 0;
  always @(posedge clk) begin
    if (greset) begin
      th <= 0; tv <= 0;
      d1h <= 0; d1v <= 0; d2h <= 0; d2v <= 0; d3h <= 0; d3v <= 0;
    end else begin
      th <= (th == H_FRAME - 1) ? 0 : th + 1;
      if (th == H_FRAME - 1) tv <= (tv == V_FRAME - 1) ? 0 : tv + 1;
      d1h <= th;  d1v <= tv;
      d2h <= d1h; d2v <= d1v;
      d3h <= d2h; d3v <= d2v;
    end
  end

  int fd_count = 0;
  always @(negedge clk) if (!greset && bus.frame_done) fd_count <= fd_count + 1;

  int checks = 0, failures = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // 0 = outside, 1 = border ring, 2 = panel
  function automatic int region(input int h, input int v);
    if (h >= PAN_H0 && h <= PAN_H1 && v >= PAN_V0 && v <= PAN_V1) return 2;
    if (h >= BRD_H0 && h <= BRD_H1 && v >= BRD_V0 && v <= BRD_V1) return 1;
    return 0;
  endfunction

  task automatic check_pix(input string tag, input int h, input int v, input logic [3:0] exp);
    bit ok;
    ok = 1'b0;
    for (int i = 0; i < 2 * FRAME; i++) begin
      @(negedge clk);
      if (d3h == h && d3v == v) begin
        ok = 1'b1;
        break;
      end
    end
    if (!ok) check({tag, " timeout"}, 32'd0, 32'd1);
    else     check(tag, {20'd0, bus.vga_r, bus.vga_g, bus.vga_b}, {20'd0, exp, exp, exp});
  endtask

  // Count pixels of one region over a whole frame that differ from exp.
  task automatic scan(input string tag, input int reg_id, input logic [3:0] exp);
    int bad, seen;
    bad = 0;
    seen = 0;
    for (int i = 0; i < FRAME; i++) begin
      @(negedge clk);
      if (region(d3h, d3v) == reg_id) begin
        seen++;
        if ({bus.vga_r, bus.vga_g, bus.vga_b} !== {exp, exp, exp}) bad++;
      end
    end
    check({tag, " bad"}, bad, 0);
    if (seen == 0) check({tag, " empty"}, seen, 1);
  endtask

  task automatic spi_bit(input logic b);
    bus.spi_mosi = b;
    repeat (4) @(negedge clk);
    bus.spi_sck = 1'b1;
    repeat (4) @(negedge clk);
    bus.spi_sck = 1'b0;
  endtask

  task automatic spi_byte(input logic [7:0] b, input logic dc);
    bus.spi_dc = dc;
    for (int i = 7; i >= 0; i--) spi_bit(b[i]);
  endtask

  task automatic cs_low;
    bus.spi_cs_n = 1'b0;
    repeat (4) @(negedge clk);
  endtask

  task automatic cs_high;
    repeat (4) @(negedge clk);
    bus.spi_cs_n = 1'b1;
    repeat (8) @(negedge clk);
  endtask

  task automatic cmd(input logic [7:0] b);
    cs_low;
    spi_byte(b, 1'b0);
    cs_high;
  endtask

  int hs_low, vs_low, hs_bad, vs_bad, period, last_fall, fd_base;
  logic prev_vs;

  initial begin
    bus.spi_sck  = 1'b0;
    bus.spi_mosi = 1'b0;
    bus.spi_cs_n = 1'b1;
    bus.spi_dc   = 1'b0;

    // Reset state
    repeat (5) @(negedge clk);
    check("reset colour", {20'd0, bus.vga_r, bus.vga_g, bus.vga_b}, 32'd0);
    check("reset hsync", bus.vga_hsync, 1);
    check("reset vsync", bus.vga_vsync, 1);
    check("reset frame_done", bus.frame_done, 0);
    greset = 1'b0;
    repeat (8) @(negedge clk);

    // Sync timing over two frames
    hs_low = 0; vs_low = 0; hs_bad = 0; vs_bad = 0; period = 0; last_fall = -1;
    prev_vs = bus.vga_vsync;
    for (int i = 0; i < 2 * FRAME; i++) begin
      @(negedge clk);
      if (!bus.vga_hsync) hs_low++;
      if (!bus.vga_vsync) vs_low++;
      if (bus.vga_hsync !== (d3h >= H_PULSE)) hs_bad++;
      if (bus.vga_vsync !== (d3v >= V_PULSE)) vs_bad++;
      if (prev_vs && !bus.vga_vsync) begin
        if (last_fall >= 0) period = i - last_fall;
        last_fall = i;
      end
      prev_vs = bus.vga_vsync;
    end
    check("hsync low clocks", hs_low, 2 * V_FRAME * H_PULSE);
    check("vsync low clocks", vs_low, 2 * V_PULSE * H_FRAME);
    check("vsync period", period, FRAME);
    check("hsync alignment", hs_bad, 0);
    check("vsync alignment", vs_bad, 0);
    scan("idle outside", 0, 4'h0);

    // Clear the buffer with one full frame of zero bytes
    fd_base = fd_count;
    cs_low;
    for (int i = 0; i < 16; i++) spi_byte(8'h00, 1'b1);
    cs_high;
    check("clear frame_done", fd_count - fd_base, 1);
    scan("clear panel", 2, 4'h0);
    scan("clear ring", 1, 4'hF);
    check_pix("brd top left", 10, 6, 4'hF);
    check_pix("brd top right", 37, 6, 4'hF);
    check_pix("past brd right", 38, 6, 4'h0);
    check_pix("left of brd", 9, 20, 4'h0);
    check_pix("brd left0", 10, 20, 4'hF);
    check_pix("brd left1", 11, 20, 4'hF);
    check_pix("panel edge", 12, 20, 4'h0);
    check_pix("brd bottom", 37, 57, 4'hF);
    check_pix("below brd", 20, 58, 4'h0);

    // Byte 0x01 to page 0 col 0 and 0x02 to page 1 col 0
    fd_base = fd_count;
    cs_low;
    spi_byte(8'h01, 1'b1);
    for (int i = 0; i < 7; i++) spi_byte(8'h00, 1'b1);
    spi_byte(8'h02, 1'b1);
    cs_high;
    check("short burst frame_done", fd_count - fd_base, 0);
    check_pix("px0 top", 12, 8, 4'hF);
    check_pix("px1 dark", 15, 8, 4'h0);
    check_pix("px0 scaled corner", 14, 10, 4'hF);
    check_pix("row1 dark", 12, 11, 4'h0);
    check_pix("page1 row8 dark", 12, 34, 4'h0);
    check_pix("page1 row9 lit", 12, 35, 4'hF);
    check_pix("page1 row9 corner", 14, 37, 4'hF);
    check_pix("page1 row10 dark", 12, 38, 4'h0);

    // Full frame of 0xFF, then one more byte wraps to address 0
    fd_base = fd_count;
    cs_low;
    for (int i = 0; i < 15; i++) spi_byte(8'hFF, 1'b1);
    check("fd before last byte", fd_count - fd_base, 0);
    spi_byte(8'hFF, 1'b1);
    repeat (2) @(negedge clk);
    check("fd after last byte", fd_count - fd_base, 1);
    scan("full panel", 2, 4'hF);
    spi_byte(8'h00, 1'b1);
    cs_high;
    check("fd after wrap byte", fd_count - fd_base, 1);
    check_pix("wrap addr0", 12, 8, 4'h0);
    check_pix("wrap addr1", 15, 8, 4'hF);
    check_pix("wrap addr0 row7", 12, 31, 4'h0);
    check_pix("wrap addr8", 12, 32, 4'hF);

    // Partial byte discarded by cs_n rising, then 0x80 lands at address 0
    fd_base = fd_count;
    cs_low;
    spi_bit(1'b1); spi_bit(1'b0); spi_bit(1'b1); spi_bit(1'b0); spi_bit(1'b1);
    cs_high;
    cs_low;
    spi_byte(8'h80, 1'b1);
    cs_high;
    check("partial frame_done", fd_count - fd_base, 0);
    check_pix("partial row0", 12, 8, 4'h0);
    check_pix("partial addr1", 15, 8, 4'hF);
    check_pix("partial row6", 12, 26, 4'h0);
    check_pix("partial row7", 12, 29, 4'hF);
    check_pix("partial row7 corner", 14, 31, 4'hF);

`ifdef OLED_VGA_CMD_DECODE_EN
    cmd(8'hA7);
    check_pix("inv addr0 row0", 12, 8, 4'hF);
    check_pix("inv addr1", 15, 8, 4'h0);
    check_pix("inv border", 10, 20, 4'hF);
    check_pix("inv addr0 row7", 12, 29, 4'h0);
    cmd(8'hAE);
    check_pix("off addr0 row0", 12, 8, 4'h0);
    check_pix("off border", 10, 20, 4'hF);
    scan("off panel", 2, 4'h0);
    cs_low;
    spi_byte(8'h81, 1'b0);
    spi_byte(8'hAF, 1'b0);
    cs_high;
    check_pix("arg ignored", 12, 8, 4'h0);
    cmd(8'hAF);
    check_pix("on inverse", 12, 8, 4'hF);
    cmd(8'hA6);
    check_pix("normal addr0 row0", 12, 8, 4'h0);
    check_pix("normal addr0 row7", 12, 29, 4'hF);
`else
    // Command bytes are dropped and do not advance the write address
    cs_low;
    spi_byte(8'hA7, 1'b0);
    spi_byte(8'h01, 1'b1);
    cs_high;
    check_pix("cmd dropped row0", 12, 8, 4'hF);
    check_pix("cmd dropped addr1", 15, 8, 4'hF);
    check_pix("cmd dropped row7", 12, 29, 4'h0);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    repeat (150000) @(posedge clk);
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule
